// File: rtl/fir_coef_loader_pkg.sv
// fir_coef_loader_pkg: shared FSM state encoding and default parameter values
package fir_coef_loader_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, WRITE, READ, DONE} state_t;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam int TIMEOUT_DEF = 15;
  localparam bit WR_ACK_REQ_DEF = 1'b0;
endpackage

// File: rtl/fir_coef_loader_wb_tmo_cnt.sv
// wb_tmo_cnt: counts strobe-high cycles and flags the last allowed cycle
module wb_tmo_cnt #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stb,
  output logic tmo
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= stb ? cnt + 1'b1 : '0;
  assign tmo = stb && cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/fir_coef_loader.sv
// fir_coef_loader: streams coefficient words into Wishbone registers with optional read-back verify
module fir_coef_loader
  import fir_coef_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter bit WR_ACK_REQ = WR_ACK_REQ_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [6:0]        cmd_count,
  input  logic              cmd_verify,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic [ADDR_W-1:0] wb_adr,
  output logic [DATA_W-1:0] wb_wr_dat,
  input  logic [DATA_W-1:0] wb_rd_dat,
  output logic              wb_we,
  output logic [DATA_W/8-1:0] wb_sel,
  output logic              wb_stb,
  output logic              wb_cyc,
  input  logic              wb_ack,
  input  logic              wb_err,
  output logic              busy,
  output logic              done,
  output logic              st_err,
  output logic              st_tmo,
  output logic [7:0]        mis_cnt
);
  state_t state, state_n;
  logic [ADDR_W-1:0] base;
  logic [6:0] count, idx, idx_n;
  logic verify, stb_n, we_n, set_err, set_tmo, mis_inc, last, tmo, cmd_go, s_go;
  assign cmd_go = cmd_valid && cmd_ready;
  assign s_go = s_valid && s_ready;
  assign last = idx + 7'd1 == count;
  assign wb_cyc = wb_stb;
  assign wb_sel = {(DATA_W/8){wb_stb}};
  wb_tmo_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (.clk(clk), .rst_n(rst_n), .stb(wb_stb), .tmo(tmo));
  always_comb begin
    state_n = state;
    stb_n = 1'b0;
    we_n = wb_we;
    idx_n = idx;
    set_err = 1'b0;
    set_tmo = 1'b0;
    mis_inc = 1'b0;
    case (state)
      IDLE: if (cmd_go) begin
        state_n = cmd_count == 7'd0 ? DONE : FETCH;
        idx_n = '0;
      end
      FETCH: if (s_go) begin
        state_n = WRITE;
        stb_n = 1'b1;
        we_n = 1'b1;
      end
      WRITE: if (wb_err) begin
        set_err = 1'b1;
        state_n = DONE;
      end else if (wb_ack || !WR_ACK_REQ) begin
        state_n = verify ? READ : last ? DONE : FETCH;
        we_n = 1'b0;
        idx_n = verify ? idx : idx + 7'd1;
      end else if (tmo) begin
        set_tmo = 1'b1;
        state_n = DONE;
      end else stb_n = 1'b1;
      READ: if (!wb_stb) stb_n = 1'b1;
      else if (wb_err) begin
        set_err = 1'b1;
        state_n = DONE;
      end else if (wb_ack) begin
        mis_inc = wb_rd_dat != wb_wr_dat;
        idx_n = idx + 7'd1;
        state_n = last ? DONE : FETCH;
      end else if (tmo) begin
        set_tmo = 1'b1;
        state_n = DONE;
      end else stb_n = 1'b1;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      base <= '0;
      count <= '0;
      idx <= '0;
      verify <= 1'b0;
      cmd_ready <= 1'b0;
      s_ready <= 1'b0;
      wb_adr <= '0;
      wb_wr_dat <= '0;
      wb_we <= 1'b0;
      wb_stb <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      st_err <= 1'b0;
      st_tmo <= 1'b0;
      mis_cnt <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      wb_stb <= stb_n;
      wb_we <= we_n;
      cmd_ready <= state_n == IDLE;
      s_ready <= state_n == FETCH;
      busy <= state_n != IDLE;
      done <= state_n == DONE;
      if (cmd_go) begin
        base <= cmd_base;
        count <= cmd_count;
        verify <= cmd_verify;
      end
      if (s_go) begin
        wb_wr_dat <= s_data;
        wb_adr <= base + ADDR_W'(idx);
      end
      st_err <= !cmd_go && (st_err || set_err);
      st_tmo <= !cmd_go && (st_tmo || set_tmo);
      if (cmd_go) mis_cnt <= '0;
      else if (mis_inc && mis_cnt != 8'hFF) mis_cnt <= mis_cnt + 8'd1;
    end
endmodule
